switch_debouncer: RTL and testbench

//   Two-channel input conditioner for raw board switches and pushbuttons.

---
 rtl/switch_debouncer_if.sv | 42 ++++
 rtl/switch_debouncer.sv | 162 ++++++++++++++++
 tb/tb_switch_debouncer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer_if
//  Description : Switch-side signal bundle for the two-channel debouncer.
//                Raw board inputs travel one way, the conditioned levels and
//                rising-edge pulses travel back.
//  Revision    : 1.0  initial release
// ============================================================================
interface switch_debouncer_if;

    // Raw, asynchronous switch / pushbutton levels
    logic x_raw;
    logic y_raw;

    // Clean, registered levels and one-cycle rising-edge pulses
    logic x;
    logic y;
    logic x_rise;
    logic y_rise;

    // Board / stimulus side: drives raw inputs, observes conditioned outputs
    modport master (
        output x_raw,
        output y_raw,
        input  x,
        input  y,
        input  x_rise,
        input  y_rise
    );

    // Debouncer side: consumes raw inputs, produces conditioned outputs
    modport slave (
        input  x_raw,
        input  y_raw,
        output x,
        output y,
        output x_rise,
        output y_rise
    );

endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Two-channel input conditioner. Each raw input is brought into
//                the clk domain by a flop chain, then filtered by a debounce
//                FSM that only accepts a new level after DEBOUNCE_CYCLES
//                consecutive matching synchronized samples. Each channel also
//                produces a registered one-cycle pulse on a 0->1 transition.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_debouncer_if.slave   sw
);

    localparam int NUM_CH = 2;

    // Terminal count: a pending change is accepted when the counter sits here
    // and the synchronized input still holds the new level.
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Value loaded when leaving a stable state. With a single-cycle debounce
    // the terminal count is zero, so loading zero makes the pending state
    // exit on the very next edge and keeps the counter within range.
    localparam logic [CNT_WIDTH-1:0] c_cnt_load =
        (DEBOUNCE_CYCLES > 1) ? CNT_WIDTH'(1) : '0;

    typedef enum logic [1:0] {
        ST_LO = 2'd0,   // stable low
        ST_PH = 2'd1,   // pending high: qualifying a 0->1 change
        ST_HI = 2'd2,   // stable high
        ST_PL = 2'd3    // pending low: qualifying a 1->0 change
    } state_t;

    // Channel 0 is X, channel 1 is Y
    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_out;
    logic [NUM_CH-1:0] w_rise;

    assign w_raw = {sw.y_raw, sw.x_raw};

    assign sw.x      = w_out[0];
    assign sw.y      = w_out[1];
    assign sw.x_rise = w_rise[0];
    assign sw.y_rise = w_rise[1];

    // Identical, fully independent logic per channel
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;

        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_WIDTH-1:0]   r_cnt;
        logic [CNT_WIDTH-1:0]   w_cnt_nxt;
        logic                   r_out;
        logic                   w_out_nxt;
        logic                   r_rise;
        logic                   w_rise_nxt;

        // Synchronizer chain: shift the raw level in, oldest stage is used
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        // FSM, counter and output registers; reset discards any pending count
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= ST_LO;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_rise  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
                r_rise  <= w_rise_nxt;
            end
        end

        // Next-state, counter and output decode
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_out_nxt   = r_out;
            w_rise_nxt  = 1'b0;

            case (r_state)
                ST_LO: begin
                    w_out_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    if (w_s) begin
                        w_state_nxt = ST_PH;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end

                ST_PH: begin
                    if (!w_s) begin
                        // Bounce back: abandon the change, count restarts later
                        w_state_nxt = ST_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_max) begin
                        w_state_nxt = ST_HI;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
                    end
                end

                ST_HI: begin
                    w_out_nxt = 1'b1;
                    w_cnt_nxt = '0;
                    if (!w_s) begin
                        w_state_nxt = ST_PL;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end

                ST_PL: begin
                    if (w_s) begin
                        w_state_nxt = ST_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_max) begin
                        // Falling acceptance never produces a rise pulse
                        w_state_nxt = ST_LO;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
                    end
                end

                default: begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                end
            endcase
        end

        assign w_out[ch]  = r_out;
        assign w_rise[ch] = r_rise;

    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Directed, self-checking bench for switch_debouncer with
//                DEBOUNCE_CYCLES=4 and SYNC_STAGES=2, so a clean change shows
//                on the outputs at the 6th edge counted from the edge that
//                first samples the new raw level.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_switch_debouncer;

    logic clk;
    logic rst_n;

    int vectors = 0;
    int miscompares = 0;

    switch_debouncer_if sw ();

    switch_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (20)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw.slave)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point: counts every vector, reports any miscompare
    task automatic check_val(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all four outputs against expected values
    task automatic check_all(input string tag, input logic ex, input logic exr,
                             input logic ey, input logic eyr);
        check_val({tag, " x"},      sw.x,      ex);
        check_val({tag, " x_rise"}, sw.x_rise, exr);
        check_val({tag, " y"},      sw.y,      ey);
        check_val({tag, " y_rise"}, sw.y_rise, eyr);
    endtask

    initial begin
        rst_n     = 1'b0;
        sw.x_raw  = 1'b0;
        sw.y_raw  = 1'b0;

        // 1. Reset for three cycles, outputs low throughout and afterwards
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all($sformatf("t1 rst e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all($sformatf("t1 post e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 2. Clean X rise: x and a single x_rise at edge 6, y untouched
        sw.x_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_all($sformatf("t2 rise e%0d", e), 1'(e >= 6), 1'(e == 6), 1'b0, 1'b0);
        end
        // Clean X fall: x drops at edge 6, no rise pulse
        sw.x_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_all($sformatf("t2 fall e%0d", e), 1'(e < 6), 1'b0, 1'b0, 1'b0);
        end

        // 3. Three-cycle pulse is one sample short of acceptance
        sw.x_raw = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all($sformatf("t3 hi e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        sw.x_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_all($sformatf("t3 lo e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 4. Bounce 1,0,1,0 then hold 1; final sampling edge is e5, accept at e10
        for (int e = 1; e <= 12; e++) begin
            case (e)
                1, 3:    sw.x_raw = 1'b1;
                2, 4:    sw.x_raw = 1'b0;
                default: sw.x_raw = 1'b1;
            endcase
            tick();
            check_all($sformatf("t4 bounce e%0d", e), 1'(e >= 10), 1'(e == 10), 1'b0, 1'b0);
        end
        sw.x_raw = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        check_val("t4 settle x", sw.x, 1'b0);

        // 5. X and Y rise on the same edge: both accepted together at edge 6
        sw.x_raw = 1'b1;
        sw.y_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_all($sformatf("t5 both e%0d", e), 1'(e >= 6), 1'(e == 6), 1'(e >= 6), 1'(e == 6));
        end
        sw.y_raw = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        check_all("t5 settle", 1'b1, 1'b0, 1'b0, 1'b0);

        // 6. Reset while x is high and x_raw stays high
        rst_n = 1'b0;
        tick();
        check_all("t6 in rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_all($sformatf("t6 release e%0d", e), 1'(e >= 6), 1'(e == 6), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
